// File: rtl/regfile_wb_queue_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue_if
//   Bundle of signals between the write-back stage, the register-file write
//   port and the forwarding readers on one side, and the write-back queue on
//   the other side.
//
//   Modports:
//     master : the pipeline / register-file side (drives pushes, rf_busy and
//              lookup addresses; observes queue status, rf_* and fwd_*).
//     slave  : the write-back queue itself.
//
//   Signals:
//     push_valid/push_addr/push_data/push_ready : pipeline write requests
//     rf_busy, rf_wen/rf_waddr/rf_wdata         : register-file write port
//     rd_addr1/fwd_hit1/fwd_data1               : forwarding lookup port 1
//     rd_addr2/fwd_hit2/fwd_data2               : forwarding lookup port 2
//     count, empty                              : occupancy status
// -----------------------------------------------------------------------------
interface regfile_wb_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              push_valid;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;

    logic              rf_busy;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [ADDR_W-1:0] rd_addr1;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;

    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output push_valid, push_addr, push_data, rf_busy, rd_addr1, rd_addr2,
        input  push_ready, rf_wen, rf_waddr, rf_wdata,
        input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty
    );

    modport slave (
        input  push_valid, push_addr, push_data, rf_busy, rd_addr1, rd_addr2,
        output push_ready, rf_wen, rf_waddr, rf_wdata,
        output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//   Write-back queue in front of the register file's single write port.
//   Register writes from the pipeline are buffered in a circular queue and
//   drained in push order, one per cycle, whenever the write port is free.
//   Two combinational forwarding lookups let readers see values that are still
//   pending in the queue (youngest matching entry wins).
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active-high; discards every pending entry
//     bus  : regfile_wb_queue_if.slave (push, rf write, forwarding, status)
//
//   Optional feature (macro WBQ_COALESCE_EN):
//     defined   : a push to an address already pending overwrites that entry's
//                 data in place (no new entry, push_ready not needed), except
//                 when the match is the head retiring in the same cycle.
//     undefined : every accepted non-R0 push allocates a new entry.
//
//   R0 is hard-wired zero: pushes to address 0 complete the handshake but are
//   discarded, and lookups of address 0 never hit.
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage. Address/data carry no reset; the valid bits qualify them.
    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];

    logic [DEPTH-1:0]  entry_valid_reg, entry_valid_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic              empty_int;
    logic              ready_int;
    logic              drain;
    logic              push_nz;
    logic              coal_hit;
    logic              push_fire;

    // ------------------------------------------------------------------
    // Status and handshake. push_ready looks only at the registered count,
    // so a full queue refuses pushes even while it is draining.
    // ------------------------------------------------------------------
    assign empty_int = (count_reg == '0);
    assign ready_int = (count_reg < CNT_W'(DEPTH));
    assign drain     = !empty_int && !bus.rf_busy;
    assign push_nz   = bus.push_valid && (bus.push_addr != '0);

`ifdef WBQ_COALESCE_EN
    // A pending entry for the same register absorbs the push, unless that
    // entry is the head being written this very cycle (it is gone after the
    // edge, so the new value must get its own slot).
    logic [DEPTH-1:0] coal_match;
    logic [PTR_W-1:0] coal_idx;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_coal
            assign coal_match[gi] = entry_valid_reg[gi]
                                 && (entry_addr[gi] == bus.push_addr)
                                 && !(drain && (rd_ptr_reg == PTR_W'(gi)));
        end
    endgenerate

    // At most one entry per address can be pending, so any set bit is the one.
    always_comb begin
        coal_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (coal_match[k]) begin
                coal_idx = PTR_W'(k);
            end
        end
    end

    assign coal_hit = push_nz && (coal_match != '0);
`else
    assign coal_hit = 1'b0;
`endif

    assign push_fire = push_nz && ready_int && !coal_hit;

    // ------------------------------------------------------------------
    // Next-state for pointers, count and valid bits. push_fire and drain
    // never target the same slot: that would need count to be both 0 and
    // DEPTH at once.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;
        entry_valid_next = entry_valid_reg;

        if (drain) begin
            rd_ptr_next                  = rd_ptr_reg + PTR_W'(1);
            entry_valid_next[rd_ptr_reg] = 1'b0;
        end
        if (push_fire) begin
            wr_ptr_next                  = wr_ptr_reg + PTR_W'(1);
            entry_valid_next[wr_ptr_reg] = 1'b1;
        end

        case ({push_fire, drain})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            entry_valid_reg <= '0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            entry_valid_reg <= entry_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            entry_addr[wr_ptr_reg] <= bus.push_addr;
            entry_data[wr_ptr_reg] <= bus.push_data;
        end
`ifdef WBQ_COALESCE_EN
        else if (coal_hit) begin
            entry_data[coal_idx] <= bus.push_data;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Register-file write port: head entry, forced to zero when empty.
    // ------------------------------------------------------------------
    assign bus.rf_wen     = drain;
    assign bus.rf_waddr   = empty_int ? '0 : entry_addr[rd_ptr_reg];
    assign bus.rf_wdata   = empty_int ? '0 : entry_data[rd_ptr_reg];
    assign bus.push_ready = ready_int;
    assign bus.count      = count_reg;
    assign bus.empty      = empty_int;

    // ------------------------------------------------------------------
    // Forwarding lookups. Entries are visited oldest to youngest starting
    // at the head, so the last match seen is the youngest. The head being
    // written this cycle is still valid and therefore still searched.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic [ADDR_W-1:0] look_addr;
            logic [PTR_W-1:0]  idx;
            logic              hit;
            logic [DATA_W-1:0] data;

            assign look_addr = (gi == 0) ? bus.rd_addr1 : bus.rd_addr2;

            always_comb begin
                idx  = '0;
                hit  = 1'b0;
                data = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    idx = rd_ptr_reg + PTR_W'(k);
                    if (entry_valid_reg[idx] && (look_addr != '0)
                            && (entry_addr[idx] == look_addr)) begin
                        hit  = 1'b1;
                        data = entry_data[idx];
                    end
                end
            end
        end
    endgenerate

    assign bus.fwd_hit1  = g_fwd[0].hit;
    assign bus.fwd_data1 = g_fwd[0].data;
    assign bus.fwd_hit2  = g_fwd[1].hit;
    assign bus.fwd_data2 = g_fwd[1].data;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_queue
//   Self-checking bench for regfile_wb_queue. A queue-based reference model
//   tracks pending writes; every negative clock edge all outputs are compared
//   against it. Directed sequences add hand-computed literal expectations.
//   Build with +define+WBQ_COALESCE_EN to exercise the coalescing variant.
// -----------------------------------------------------------------------------
module tb_regfile_wb_queue;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

`ifdef WBQ_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic clk;
    logic rst;

    regfile_wb_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an ordered list of pending (addr, data) writes.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_drain;
    bit   m_push;
    bit   m_coal;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_drain = (mq.size() > 0) && !bus.rf_busy;
            m_coal  = 1'b0;
            m_push  = 1'b0;
            if (bus.push_valid && bus.push_addr != 0) begin
                if (COAL) begin
                    for (int i = (m_drain ? 1 : 0); i < mq.size(); i++) begin
                        if (mq[i].a == bus.push_addr) begin
                            mq[i].d = bus.push_data;
                            m_coal  = 1'b1;
                            $display("merge r%0d <= %h", bus.push_addr, bus.push_data);
                        end
                    end
                end
                if (!m_coal && mq.size() < DEPTH) m_push = 1'b1;
            end
            if (m_drain) begin
                $display("write r%0d = %h", mq[0].a, mq[0].d);
                void'(mq.pop_front());
            end
            if (m_push) begin
                $display("push  r%0d <= %h", bus.push_addr, bus.push_data);
                mq.push_back('{a: bus.push_addr, d: bus.push_data});
            end
        end
    end

    // Youngest pending match for a lookup address; address 0 never matches.
    function automatic void model_fwd(input logic [ADDR_W-1:0] ra,
                                      output int hit, output int data);
        hit  = 0;
        data = 0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (ra != 0 && mq[i].a == ra) begin
                hit  = 1;
                data = int'(mq[i].d);
                break;
            end
        end
    endfunction

    always @(negedge clk) begin
        int h, d, sz;
        sz = mq.size();
        chk("count",      int'(bus.count),      sz);
        chk("empty",      int'(bus.empty),      (sz == 0) ? 1 : 0);
        chk("push_ready", int'(bus.push_ready), (sz < DEPTH) ? 1 : 0);
        chk("rf_wen",     int'(bus.rf_wen),     (sz > 0 && !bus.rf_busy) ? 1 : 0);
        chk("rf_waddr",   int'(bus.rf_waddr),   (sz > 0) ? int'(mq[0].a) : 0);
        chk("rf_wdata",   int'(bus.rf_wdata),   (sz > 0) ? int'(mq[0].d) : 0);
        model_fwd(bus.rd_addr1, h, d);
        chk("fwd_hit1",   int'(bus.fwd_hit1),   h);
        chk("fwd_data1",  int'(bus.fwd_data1),  d);
        model_fwd(bus.rd_addr2, h, d);
        chk("fwd_hit2",   int'(bus.fwd_hit2),   h);
        chk("fwd_data2",  int'(bus.fwd_data2),  d);
    end

    // ------------------------------------------------------------------
    // Directed stimulus. Inputs change 1 time unit after a rising edge;
    // literal checks are taken 2 units later, well before the falling edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int d);
        bus.push_valid = 1'b1;
        bus.push_addr  = ADDR_W'(a);
        bus.push_data  = DATA_W'(d);
    endtask

    initial begin
        int order [4];
        rst            = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_addr  = '0;
        bus.push_data  = '0;
        bus.rf_busy    = 1'b0;
        bus.rd_addr1   = '0;
        bus.rd_addr2   = '0;

        // ---- 1: reset values, then reset with three entries pending ----
        tick(); tick();
        chk("rst_rf_wen",     int'(bus.rf_wen),     0);
        chk("rst_rf_waddr",   int'(bus.rf_waddr),   0);
        chk("rst_rf_wdata",   int'(bus.rf_wdata),   0);
        chk("rst_push_ready", int'(bus.push_ready), 1);
        chk("rst_empty",      int'(bus.empty),      1);
        chk("rst_fwd_hit1",   int'(bus.fwd_hit1),   0);
        rst         = 1'b0;
        bus.rf_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push(i, 'h0010 + i);
            tick();
        end
        bus.push_valid = 1'b0;
        bus.rd_addr1   = 4'd2;
        #2;
        chk("t1_count_pending", int'(bus.count),     3);
        chk("t1_fwd_before",    int'(bus.fwd_data1), 'h0012);
        bus.rf_busy = 1'b0;
        rst         = 1'b1;
        #1;
        chk("t1_async_count", int'(bus.count),      0);
        chk("t1_async_wen",   int'(bus.rf_wen),     0);
        chk("t1_async_ready", int'(bus.push_ready), 1);
        chk("t1_async_fwd",   int'(bus.fwd_hit1),   0);
        tick();
        rst          = 1'b0;
        bus.rd_addr1 = '0;
        #2;
        chk("t1_after_wen",   int'(bus.rf_wen), 0);
        chk("t1_after_count", int'(bus.count),  0);
        tick();

        // ---- 2: single push, no flow-through, written next cycle ----
        push(3, 'h1234);
        #2;
        chk("t2_no_flow_wen", int'(bus.rf_wen), 0);
        tick();
        bus.push_valid = 1'b0;
        #2;
        chk("t2_wen",   int'(bus.rf_wen),   1);
        chk("t2_waddr", int'(bus.rf_waddr), 3);
        chk("t2_wdata", int'(bus.rf_wdata), 'h1234);
        tick();
        #2;
        chk("t2_count_after", int'(bus.count), 0);
        tick();

        // ---- 3: fill while busy, 5th push ignored, drain in order ----
        bus.rf_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(i, 'h0100 + i);
            tick();
        end
        push(5, 'h0555);
        #2;
        chk("t3_ready_full", int'(bus.push_ready), 0);
        chk("t3_count_full", int'(bus.count),      4);
        tick();
        bus.push_valid = 1'b0;
        bus.rf_busy    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #2;
            chk("t3_drain_wen",   int'(bus.rf_wen),   1);
            chk("t3_drain_addr",  int'(bus.rf_waddr), i);
            chk("t3_drain_data",  int'(bus.rf_wdata), 'h0100 + i);
            chk("t3_drain_count", int'(bus.count),    5 - i);
            tick();
        end
        #2;
        chk("t3_empty", int'(bus.empty), 1);
        tick();

        // ---- 4: two pushes to R5, youngest value forwarded ----
        bus.rf_busy = 1'b1;
        push(5, 'hAAAA);
        tick();
        push(5, 'hBBBB);
        tick();
        bus.push_valid = 1'b0;
        bus.rd_addr1   = 4'd5;
        #2;
        chk("t4_fwd_hit1",  int'(bus.fwd_hit1),  1);
        chk("t4_fwd_data1", int'(bus.fwd_data1), 'hBBBB);
        chk("t4_count",     int'(bus.count),     COAL ? 1 : 2);
        tick();
        bus.rf_busy  = 1'b0;
        bus.rd_addr1 = '0;
        repeat (3) tick();
        #2;
        chk("t4_empty", int'(bus.empty), 1);
        tick();

        // ---- 5: push to R0 accepted but dropped; R0 lookup never hits ----
        push(0, 'hFFFF);
        bus.rd_addr2 = '0;
        #2;
        chk("t5_ready", int'(bus.push_ready), 1);
        tick();
        bus.push_valid = 1'b0;
        #2;
        chk("t5_count",    int'(bus.count),    0);
        chk("t5_wen",      int'(bus.rf_wen),   0);
        chk("t5_fwd_hit2", int'(bus.fwd_hit2), 0);
        tick();

        // ---- 6: full queue with push held high; accepted after a drain ----
        bus.rf_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(i, 'h0600 + i);
            tick();
        end
        push(6, 'h6666);
        bus.rf_busy  = 1'b0;
        bus.rd_addr2 = 4'd6;
        #2;
        chk("t6_full_ready", int'(bus.push_ready), 0);
        chk("t6_full_wen",   int'(bus.rf_wen),     1);
        chk("t6_no_fwd",     int'(bus.fwd_hit2),   0);
        tick();
        bus.rf_busy = 1'b1;
        #2;
        chk("t6_ready_after", int'(bus.push_ready), 1);
        chk("t6_count_after", int'(bus.count),      3);
        tick();
        bus.push_valid = 1'b0;
        #2;
        chk("t6_count_back", int'(bus.count),     4);
        chk("t6_fwd_new",    int'(bus.fwd_data2), 'h6666);
        tick();
        bus.rf_busy = 1'b0;
        order[0] = 2; order[1] = 3; order[2] = 4; order[3] = 6;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t6_order", int'(bus.rf_waddr), order[i]);
            tick();
        end
        bus.rd_addr2 = '0;
        #2;
        chk("t6_empty", int'(bus.empty), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
